// File: rtl/password_enroller_if.sv
// Switch-panel bus between the lock panel/checker and the password enroller.
// The master drives switches and the read address; the slave drives the table read and status.
interface password_enroller_if;
  logic [17:0] s;
  logic [3:0]  rd_idx;
  logic [15:0] rd_pw;
  logic        busy;
  logic        locked;
  logic [3:0]  slot;
  logic [2:0]  state;
  logic [2:0]  status;

  modport master (output s, rd_idx, input rd_pw, busy, locked, slot, state, status);
  modport slave  (input s, rd_idx, output rd_pw, busy, locked, slot, state, status);
endinterface

// File: rtl/password_enroller.sv
// Password table owner and key-stepped change-password sequencer.
// Define PASSWORD_ENROLLER_LOCKOUT_EN to enable failed-auth lockout.
module password_enroller #(
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_PRESSES = 8
) (
  input  logic                 key,
  input  logic                 reset,
  password_enroller_if.slave   bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, AUTH = 3'd1, NEW = 3'd2, CONFIRM = 3'd3, LOCKED = 3'd4} state_t;
  typedef enum logic [2:0] {ST_NONE = 3'd0, ST_OK = 3'd1, ST_AUTHFAIL = 3'd2, ST_MISMATCH = 3'd3,
                            ST_DUP = 3'd4, ST_ABORT = 3'd5, ST_LOCKOUT = 3'd6} status_t;

  // Factory table; element 0 is the rightmost entry.
  localparam logic [15:0][15:0] PW_DEF = {
    16'h0001, 16'h0202, 16'habcd, 16'hcdef, 16'hdaff, 16'h80a1, 16'h9090, 16'h8973,
    16'habab, 16'hbaba, 16'hf42a, 16'hc35f, 16'hc9c9, 16'h649b, 16'h459a, 16'hef93};

  if (MAX_FAILS < 1 || MAX_FAILS > 7 || LOCK_PRESSES < 1 || LOCK_PRESSES > 255) begin : g_param_err
    $error("password_enroller: MAX_FAILS or LOCK_PRESSES out of range");
  end

  logic [15:0] tbl [16];
  state_t      state, state_nxt;
  status_t     status, status_nxt;
  logic [3:0]  slot, slot_nxt;
  logic [15:0] pending, pend_nxt;
  logic        wr_en;
  logic [15:0] dup_hit;
  logic        dup, abort;
  logic [15:0] val;

  assign val   = bus.s[15:0];
  assign abort = bus.s[17];

  // A new password may match only its own slot, so the checker never sees two hits.
  for (genvar j = 0; j < 16; j++) begin : g_dup
    assign dup_hit[j] = (tbl[j] == val) && (slot != 4'(j));
  end
  assign dup = |dup_hit;

`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
  logic [2:0] fail_cnt, fail_nxt;
  logic [7:0] lock_cnt, lock_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    status_nxt = status;
    slot_nxt   = slot;
    pend_nxt   = pending;
    wr_en      = 1'b0;
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
    fail_nxt   = fail_cnt;
    lock_nxt   = lock_cnt;
`endif
    case (state)
      IDLE: if (bus.s[16]) begin
        slot_nxt   = bus.s[3:0];
        state_nxt  = AUTH;
        status_nxt = ST_NONE;
      end
      AUTH: begin
        if (abort) begin
          state_nxt  = IDLE;
          status_nxt = ST_ABORT;
        end else if (val == tbl[slot]) begin
          state_nxt = NEW;
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
          fail_nxt  = '0;
`endif
        end else begin
          state_nxt  = IDLE;
          status_nxt = ST_AUTHFAIL;
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
          fail_nxt   = fail_cnt + 3'd1;
          if (fail_nxt == 3'(MAX_FAILS)) begin
            state_nxt  = LOCKED;
            lock_nxt   = 8'(LOCK_PRESSES);
            status_nxt = ST_LOCKOUT;
          end
`endif
        end
      end
      NEW: begin
        state_nxt = IDLE;
        if (abort) status_nxt = ST_ABORT;
        else if (dup) status_nxt = ST_DUP;
        else begin
          pend_nxt  = val;
          state_nxt = CONFIRM;
        end
      end
      CONFIRM: begin
        state_nxt = IDLE;
        if (abort) status_nxt = ST_ABORT;
        else if (val == pending) begin
          wr_en      = 1'b1;
          status_nxt = ST_OK;
        end else status_nxt = ST_MISMATCH;
      end
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
      LOCKED: begin
        lock_nxt = lock_cnt - 8'd1;
        // lock_cnt of 0 cannot occur; treat it as expiry rather than wrapping.
        if (lock_cnt <= 8'd1) begin
          lock_nxt  = '0;
          fail_nxt  = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge key or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      status  <= ST_NONE;
      slot    <= '0;
      pending <= '0;
      for (int i = 0; i < 16; i++) tbl[i] <= PW_DEF[i];
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
      fail_cnt <= '0;
      lock_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      status  <= status_nxt;
      slot    <= slot_nxt;
      pending <= pend_nxt;
      if (wr_en) tbl[slot] <= pending;
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
      fail_cnt <= fail_nxt;
      lock_cnt <= lock_nxt;
`endif
    end
  end

  assign bus.rd_pw  = tbl[bus.rd_idx];
  assign bus.busy   = (state != IDLE);
  assign bus.slot   = slot;
  assign bus.state  = state;
  assign bus.status = status;
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
  assign bus.locked = (state == LOCKED);
`else
  assign bus.locked = 1'b0;
`endif
endmodule

// File: tb/tb_password_enroller.sv
// Directed bench for password_enroller: table defaults, change, mismatch, dup, abort, lockout, reset.
`timescale 1ns/1ps
module tb_password_enroller;
  logic key = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] exp_tbl [16];

  password_enroller_if bus();
  password_enroller dut (.key(key), .reset(reset), .bus(bus.slave));

  always #50 key = ~key;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply switches mid-low phase, then sample just after the rising edge.
  task automatic step(input logic [17:0] sv);
    @(negedge key);
    bus.s = sv;
    @(posedge key);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), 32'(bus.rd_pw), 32'(exp_tbl[i]));
    end
  endtask

  task automatic load_defaults();
    exp_tbl = '{16'hef93, 16'h459a, 16'h649b, 16'hc9c9, 16'hc35f, 16'hf42a, 16'hbaba, 16'habab,
                16'h8973, 16'h9090, 16'h80a1, 16'hdaff, 16'hcdef, 16'habcd, 16'h0202, 16'h0001};
  endtask

  initial begin
    bus.s = '0;
    bus.rd_idx = '0;
    load_defaults();
    repeat (2) @(posedge key);
    @(negedge key);
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_status", 32'(bus.status), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_slot", 32'(bus.slot), 0);
    sweep("rst");

    // Full change of slot 3
    step(18'h1_0003);
    chk("chg_req_state", 32'(bus.state), 1);
    chk("chg_req_busy", 32'(bus.busy), 1);
    chk("chg_req_slot", 32'(bus.slot), 3);
    step(18'h0_c9c9); chk("chg_auth_state", 32'(bus.state), 2);
    step(18'h0_1234); chk("chg_new_state", 32'(bus.state), 3);
    step(18'h0_1234);
    chk("chg_conf_state", 32'(bus.state), 0);
    chk("chg_conf_status", 32'(bus.status), 1);
    chk("chg_conf_busy", 32'(bus.busy), 0);
    exp_tbl[3] = 16'h1234;
    sweep("chg");

    // Confirm mismatch on slot 5
    step(18'h1_0005); step(18'h0_f42a); step(18'h0_7777); step(18'h0_7778);
    chk("mis_status", 32'(bus.status), 3);
    chk("mis_state", 32'(bus.state), 0);
    bus.rd_idx = 4'd5; #1;
    chk("mis_rd5", 32'(bus.rd_pw), 32'h f42a);

    // Duplicate of slot 6 rejected; own value accepted
    step(18'h1_0000); step(18'h0_ef93); step(18'h0_baba);
    chk("dup_status", 32'(bus.status), 4);
    chk("dup_state", 32'(bus.state), 0);
    step(18'h1_0000); step(18'h0_ef93); step(18'h0_ef93);
    chk("own_state", 32'(bus.state), 3);
    step(18'h0_ef93);
    chk("own_status", 32'(bus.status), 1);

    // Abort in CONFIRM with a matching value, then abort in AUTH with correct pw
    step(18'h1_0002); step(18'h0_649b); step(18'h0_5555);
    chk("abt_pre_state", 32'(bus.state), 3);
    step(18'h2_5555);
    chk("abt_conf_state", 32'(bus.state), 0);
    chk("abt_conf_status", 32'(bus.status), 5);
    bus.rd_idx = 4'd2; #1;
    chk("abt_rd2", 32'(bus.rd_pw), 32'h649b);
    step(18'h1_0002); step(18'h2_649b);
    chk("abt_auth_status", 32'(bus.status), 5);
    chk("abt_auth_state", 32'(bus.state), 0);

    // Three wrong authentications on slot 1
    for (int k = 0; k < 3; k++) begin
      step(18'h1_0001); step(18'h0_0000);
      if (k < 2) chk($sformatf("lk_fail%0d_status", k), 32'(bus.status), 2);
    end
`ifdef PASSWORD_ENROLLER_LOCKOUT_EN
    chk("lk_locked", 32'(bus.locked), 1);
    chk("lk_state", 32'(bus.state), 4);
    chk("lk_status", 32'(bus.status), 6);
    for (int k = 0; k < 7; k++) begin
      step(18'h1_0001);
      chk($sformatf("lk_hold%0d", k), 32'(bus.locked), 1);
    end
    step(18'h1_0001);
    chk("lk_exit_state", 32'(bus.state), 0);
    chk("lk_exit_locked", 32'(bus.locked), 0);
    chk("lk_exit_status", 32'(bus.status), 6);
`else
    chk("nolk_locked", 32'(bus.locked), 0);
    chk("nolk_state", 32'(bus.state), 0);
    chk("nolk_status", 32'(bus.status), 2);
`endif
    step(18'h1_0001); step(18'h0_459a); step(18'h0_4242); step(18'h0_4242);
    chk("post_lk_status", 32'(bus.status), 1);
    bus.rd_idx = 4'd1; #1;
    chk("post_lk_rd1", 32'(bus.rd_pw), 32'h4242);

    // Asynchronous reset while in NEW
    step(18'h1_0004); step(18'h0_c35f);
    chk("ar_pre_state", 32'(bus.state), 2);
    reset = 1'b1;
    #1;
    chk("ar_state", 32'(bus.state), 0);
    chk("ar_status", 32'(bus.status), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    load_defaults();
    sweep("ar");
    bus.s = '0;
    reset = 1'b0;
    step(18'h0_0000);
    chk("ar_after_state", 32'(bus.state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/password_enroller.md
# password_enroller

Password-table owner and change-password sequencer for the switch-panel lock. Holds the 16 account passwords that the lock's checker matches against, exposes them on a combinational read port, and runs a key-stepped enrolment sequence (select slot, prove current password, enter new, confirm) that rewrites one slot. It is the writer side of the password table the checker reads, and is clocked by the same `key` push-button.

## Interface
Parameters:
- `MAX_FAILS`, 3, consecutive failed authentications before lockout (1..7)
- `LOCK_PRESSES`, 8, `key` edges spent in lockout (1..255)

Ports:
- `key`  in  1  clock; all state advances on posedge
- `reset`  in  1  asynchronous, active-high; restores defaults
- `s`  in  18  switches: `s[15:0]` value, `s[16]` change request, `s[17]` abort
- `rd_idx`  in  4  checker read address
- `rd_pw`  out  16  `table[rd_idx]`, combinational
- `busy`  out  1  high in any state other than IDLE
- `locked`  out  1  high in LOCKED
- `slot`  out  4  slot being enrolled (latched)
- `state`  out  3  IDLE=0, AUTH=1, NEW=2, CONFIRM=3, LOCKED=4
- `status`  out  3  last result: NONE=0, OK=1, AUTHFAIL=2, MISMATCH=3, DUP=4, ABORT=5, LOCKOUT=6

## Operation
- Reset loads the table with factory defaults, slot 0..15: ef93, 459a, 649b, c9c9, c35f, f42a, baba, abab, 8973, 9090, 80a1, daff, cdef, abcd, 0202, 0001 (hex). It also sets state=IDLE, status=NONE, slot=0, busy=0, locked=0, fail_cnt=0, lock_cnt=0, and pending=0.
- IDLE: on an edge with `s[16]`=1, latch slot=`s[3:0]`, go to AUTH, and set status=NONE. With `s[16]`=0, no change.
- AUTH: if `s[15:0]`==table[slot], clear fail_cnt and go to NEW. Otherwise increment fail_cnt and set status=AUTHFAIL. If the new fail_cnt equals MAX_FAILS, go to LOCKED, load lock_cnt=LOCK_PRESSES, and set status=LOCKOUT. Else go to IDLE.
- NEW: if `s[15:0]` equals table[j] for any j≠slot, set status=DUP and go to IDLE with no write. This keeps checker matches unambiguous. Otherwise latch pending=`s[15:0]` and go to CONFIRM. Re-entering the slot's current password is allowed.
- CONFIRM: if `s[15:0]`==pending, write table[slot]=pending, set status=OK, and go to IDLE. Otherwise set status=MISMATCH and go to IDLE. No write on mismatch.
- Abort: `s[17]`=1 on an edge in AUTH, NEW or CONFIRM means go to IDLE with status=ABORT and no table or fail_cnt change. Abort has priority over that state's comparison. It is ignored in IDLE and LOCKED.
- LOCKED: each edge decrements lock_cnt. The edge that takes lock_cnt from 1 to 0 goes to IDLE and clears fail_cnt. status stays LOCKOUT until the next request. `s` is ignored.
- fail_cnt persists across IDLE visits and clears only on successful AUTH, lockout exit, or reset.

## Timing
- Single clock domain `key`. All outputs except `rd_pw` are registered and change only on posedge `key` or on `reset`.
- Every transition takes exactly 1 edge. A full change costs 4 edges: request, auth, new, confirm.
- The write lands on the CONFIRM edge. `rd_pw` shows the new value immediately after that edge (0-cycle read latency).
- Reset mid-operation (any state) discards pending and restores factory defaults. Enrolled passwords are not retained.
- Widths: fail_cnt 3 bits, lock_cnt 8 bits, no wrap. fail_cnt saturates at MAX_FAILS before LOCKED is entered.

## Configuration
- `PASSWORD_ENROLLER_LOCKOUT_EN` defined: lockout behaves as above.
- Not defined: there is no LOCKED state, fail_cnt, or lock_cnt. A failed AUTH always goes to IDLE with status=AUTHFAIL. `locked` is tied 0, and LOCKOUT is never reported. The parameters remain declared but unused.

## Test plan
- Reset, then sweep `rd_idx` 0..15 -> `rd_pw` returns the 16 defaults (slot 0 = ef93, slot 15 = 0001); state=0, status=0.
- Change slot 3: edges with `s`=1_0003, 0_c9c9, 0_1234, 0_1234 (hex, `s[16]` shown first) -> state walks 1,2,3,0, status=OK, `rd_pw`@3=1234, other slots unchanged.
- Confirm mismatch: request slot 5, auth f42a, new 7777, confirm 7778 -> status=MISMATCH, `rd_pw`@5 still f42a.
- Duplicate: request slot 0, auth ef93, new baba (slot 6) -> status=DUP, state=IDLE. Repeat with new ef93 (own value) -> accepted into CONFIRM.
- Lockout (macro on, defaults): 3 requests on slot 1, each with wrong auth 0000 -> after 3rd, locked=1, state=4, status=LOCKOUT; 7 further edges keep locked=1, 8th returns state=0, locked=0. Then a correct change on slot 1 succeeds. With the macro off, the same stimulus never sets locked.
- Abort and reset: in CONFIRM assert `s[17]` with a matching value -> status=ABORT, no write. In NEW assert `reset` asynchronously -> state=0 and table=defaults without a `key` edge.
